// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 byte transmitter between NUM_REQ requesters.
// A grant is held for a whole packet; a byte the transmitter never acknowledges is dropped.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_enable,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic            active_q, active_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_enable_q, tx_enable_d;
  logic            timeout_q, timeout_d;
  logic            last_flag_q, last_flag_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            cur_valid;
  logic            cur_last;
  logic [7:0]      cur_data;
  logic [GW-1:0]   scan;
  logic [GW-1:0]   pick_idx;
  logic            pick_found;

  always_comb begin
    cur_valid = req_valid[grant_q];
    cur_last  = req_last[grant_q];
    cur_data  = req_data[{grant_q, 3'b000} +: 8];
  end

  // Scan starts one past the previous owner so the previous owner is checked last.
  always_comb begin
    scan       = last_grant_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = (scan == GW'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
      if (!pick_found && req_valid[scan]) begin
        pick_found = 1'b1;
        pick_idx   = scan;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    active_d     = active_q;
    tx_data_d    = tx_data_q;
    tx_enable_d  = tx_enable_q;
    timeout_d    = 1'b0;
    last_flag_d  = last_flag_q;
    timer_d      = timer_q;
    req_ready    = '0;

    case (state_q)
      S_IDLE: begin
        if (!tx_busy && pick_found) begin
          grant_d  = pick_idx;
          active_d = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        req_ready[grant_q] = cur_valid;
        if (cur_valid) begin
          tx_data_d   = cur_data;
          last_flag_d = cur_last;
          timer_d     = '0;
          tx_enable_d = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          tx_enable_d = 1'b0;
          state_d     = S_WAIT;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Abandoned byte still closes the packet if it was flagged last.
          timeout_d   = 1'b1;
          tx_enable_d = 1'b0;
          state_d     = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!tx_busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (last_flag_q) begin
          last_grant_d = grant_q;
          active_d     = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      active_q     <= 1'b0;
      tx_data_q    <= '0;
      tx_enable_q  <= 1'b0;
      timeout_q    <= 1'b0;
      last_flag_q  <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      active_q     <= active_d;
      tx_data_q    <= tx_data_d;
      tx_enable_q  <= tx_enable_d;
      timeout_q    <= timeout_d;
      last_flag_q  <= last_flag_d;
      timer_q      <= timer_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_enable   = tx_enable_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues, a simple transmitter
// model that logs {grant_id, tx_data} when busy rises, and hand-computed expectations.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  p_data [4][16];
  logic        p_last [4][16];
  int unsigned p_gap  [4][16];
  int unsigned p_cnt  [4] = '{0, 0, 0, 0};
  int unsigned p_ptr  [4] = '{0, 0, 0, 0};
  int unsigned gap_cnt[4] = '{0, 0, 0, 0};
  logic [3:0]  hs_prev = '0;
  int unsigned multi_err = 0;
  int unsigned own_err   = 0;

  logic        model_en = 1'b1;
  int unsigned busy_len = 3;
  int unsigned busy_cnt = 0;
  logic [31:0] log_word [256];
  int unsigned log_n = 0;
  int unsigned chg_err = 0;

  uart_tx_scheduler #(.NUM_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .active     (active),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input int unsigned r, input logic [7:0] d, input logic l, input int unsigned g);
    p_data[r][p_cnt[r] % 16] = d;
    p_last[r][p_cnt[r] % 16] = l;
    p_gap [r][p_cnt[r] % 16] = g;
    p_cnt[r]++;
  endtask

  task automatic check_log(input string tag, input int unsigned idx, input logic [31:0] exp);
    check(tag, (idx < log_n) ? log_word[idx] : 32'hFFFF_FFFF, exp);
  endtask

  task automatic wait_log(input string tag, input int unsigned n);
    int unsigned k = 0;
    while (!(log_n >= n && !active && !tx_busy) && k < 400) begin
      tick();
      k++;
    end
    check(tag, (k < 400) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) p_cnt[i] = p_ptr[i];
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Requester model: presents queue heads at negedge, pops on accepted handshakes.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (hs_prev[i]) begin
        p_ptr[i]++;
        gap_cnt[i] = (p_ptr[i] < p_cnt[i]) ? p_gap[i][p_ptr[i] % 16] : 0;
      end
      if (p_ptr[i] < p_cnt[i] && gap_cnt[i] == 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = p_data[i][p_ptr[i] % 16];
        req_last[i]        = p_last[i][p_ptr[i] % 16];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        if (gap_cnt[i] > 0) gap_cnt[i]--;
      end
    end
    #1;
    hs_prev = req_valid & req_ready;
    if ((req_ready & (req_ready - 4'd1)) != 4'd0) multi_err++;
    if (req_ready != 4'd0 && req_ready != (4'd1 << grant_id)) own_err++;
  end

  // Transmitter model: busy for busy_len negedges after it sees tx_enable.
  initial forever begin
    @(negedge clk);
    if (tx_busy && active && log_n > 0 && {24'd0, tx_data} != (log_word[log_n-1] & 32'hFF))
      chg_err++;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end else if (model_en && tx_enable && !tx_busy) begin
      tx_busy  = 1'b1;
      busy_cnt = busy_len;
      if (log_n < 256) log_word[log_n] = {22'd0, grant_id, tx_data};
      log_n++;
    end
  end

  initial begin
    int unsigned base;
    int unsigned pulses;
    int unsigned en_low;
    int unsigned act_err;
    int unsigned k;

    tick();
    tick();
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_enable", {31'd0, tx_enable}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;

    // Single byte from requester 0: latency and handshake.
    base = log_n;
    push(0, 8'h41, 1'b1, 0);
    tick();
    check("t1_c0_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check("t1_c1_ready", {28'd0, req_ready}, 32'h1);
    check("t1_c1_active", {31'd0, active}, 32'd1);
    check("t1_c1_grant", {30'd0, grant_id}, 32'd0);
    check("t1_c1_enable", {31'd0, tx_enable}, 32'd0);
    tick();
    check("t1_c2_enable", {31'd0, tx_enable}, 32'd1);
    check("t1_c2_data", {24'd0, tx_data}, 32'h41);
    check("t1_c2_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check("t1_c3_enable", {31'd0, tx_enable}, 32'd0);
    check("t1_c3_active", {31'd0, active}, 32'd1);
    tick();
    tick();
    tick();
    check("t1_c6_active", {31'd0, active}, 32'd1);
    tick();
    check("t1_c7_active", {31'd0, active}, 32'd0);
    check_log("t1_log", base, 32'h041);

    // Requesters 0 and 2 alternate.
    apply_reset();
    base = log_n;
    push(0, 8'hA0, 1'b1, 0);
    push(0, 8'hA1, 1'b1, 0);
    push(2, 8'hC0, 1'b1, 0);
    push(2, 8'hC1, 1'b1, 0);
    wait_log("t2_done", base + 4);
    check_log("t2_b0", base + 0, 32'h0A0);
    check_log("t2_b1", base + 1, 32'h2C0);
    check_log("t2_b2", base + 2, 32'h0A1);
    check_log("t2_b3", base + 3, 32'h2C1);

    // Multi-byte packet with a mid-packet gap holds the lock against requester 3.
    apply_reset();
    base = log_n;
    push(1, 8'h10, 1'b0, 0);
    push(1, 8'h11, 1'b0, 0);
    push(1, 8'h12, 1'b1, 5);
    push(3, 8'h30, 1'b1, 0);
    wait_log("t3_done", base + 4);
    check_log("t3_b0", base + 0, 32'h110);
    check_log("t3_b1", base + 1, 32'h111);
    check_log("t3_b2", base + 2, 32'h112);
    check_log("t3_b3", base + 3, 32'h330);

    // Transmitter never responds: timeout pulse 16 cycles after START entry.
    apply_reset();
    model_en = 1'b0;
    push(0, 8'h55, 1'b1, 0);
    tick();
    tick();
    tick();
    check("t4_start_enable", {31'd0, tx_enable}, 32'd1);
    pulses = 0;
    en_low = 0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (timeout_err) pulses++;
      if (!tx_enable) en_low++;
    end
    check("t4_early_pulse", pulses, 32'd0);
    check("t4_enable_held", en_low, 32'd0);
    tick();
    check("t4_pulse", {31'd0, timeout_err}, 32'd1);
    check("t4_enable_drop", {31'd0, tx_enable}, 32'd0);
    tick();
    check("t4_pulse_end", {31'd0, timeout_err}, 32'd0);
    check("t4_released", {31'd0, active}, 32'd0);
    model_en = 1'b1;
    base = log_n;
    push(1, 8'h66, 1'b1, 0);
    wait_log("t4_next_done", base + 1);
    check_log("t4_next", base, 32'h166);

    // Reset during WAIT with the line still busy.
    apply_reset();
    busy_len = 20;
    base = log_n;
    push(2, 8'h77, 1'b1, 0);
    k = 0;
    while (!(tx_busy && active && !tx_enable) && k < 50) begin
      tick();
      k++;
    end
    check("t5_reach_wait", (k < 50) ? 32'd1 : 32'd0, 32'd1);
    busy_len = 3;
    push(0, 8'h5A, 1'b1, 0);
    push(1, 8'h5B, 1'b1, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_enable", {31'd0, tx_enable}, 32'd0);
    check("t5_active", {31'd0, active}, 32'd0);
    act_err = 0;
    k = 0;
    while (tx_busy && k < 50) begin
      if (active || req_ready != 4'd0) act_err++;
      tick();
      k++;
    end
    check("t5_no_grant_busy", act_err, 32'd0);
    wait_log("t5_done", base + 3);
    check_log("t5_b0", base + 0, 32'h277);
    check_log("t5_b1", base + 1, 32'h05A);
    check_log("t5_b2", base + 2, 32'h15B);

    // All four requesters continuously valid: strict rotation with wrap.
    apply_reset();
    base = log_n;
    for (int i = 0; i < 4; i++) begin
      push(i, 8'hE0 + 8'(i), 1'b1, 0);
      push(i, 8'hF0 + 8'(i), 1'b1, 0);
    end
    wait_log("t6_done", base + 8);
    check_log("t6_b0", base + 0, 32'h0E0);
    check_log("t6_b1", base + 1, 32'h1E1);
    check_log("t6_b2", base + 2, 32'h2E2);
    check_log("t6_b3", base + 3, 32'h3E3);
    check_log("t6_b4", base + 4, 32'h0F0);
    check_log("t6_b5", base + 5, 32'h1F1);
    check_log("t6_b6", base + 6, 32'h2F2);
    check_log("t6_b7", base + 7, 32'h3F3);

    check("ready_onehot", multi_err, 32'd0);
    check("ready_owner_only", own_err, 32'd0);
    check("tx_data_stable", chg_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
